// File: rtl/multiplier_taint_track_bitwise_pkg.sv
// Shared types and helpers for the constant-time taint-tracking multiplier.
// Holds the FSM state enum, the counter sizing function and the prefix-OR taint rule.
package mult_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Widest taint vector the prefix-OR helper accepts (2*NUM_BITS must fit).
  localparam int TAINT_MAX_W = 64;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Bit i of a sum is tainted if any addend bit at or below i is tainted,
  // since a carry can ripple from any lower position.
  function automatic logic prefix_or_bit(input logic [TAINT_MAX_W-1:0] v, input int i);
    logic r;
    r = 1'b0;
    for (int j = 0; j < TAINT_MAX_W; j++) begin
      if (j <= i) r = r | v[j];
    end
    return r;
  endfunction

endpackage

// File: rtl/multiplier_taint_track_bitwise_if.sv
// Operand/result bundle for the multiplier; taint signals exist only with MULT_TAINT_TRACK_EN.
// master drives operands and start, slave returns product and done.
interface multiplier_taint_track_bitwise_if #(
  parameter int NUM_BITS = 7
);
  logic                    start;
  logic [NUM_BITS-1:0]     multiplier;
  logic [NUM_BITS-1:0]     multiplicand;
  logic [2*NUM_BITS-1:0]   product;
  logic                    done;
`ifdef MULT_TAINT_TRACK_EN
  logic [NUM_BITS-1:0]     multiplier_taint;
  logic [NUM_BITS-1:0]     multiplicand_taint;
  logic [2*NUM_BITS-1:0]   product_taint;

  modport master (
    output start, multiplier, multiplicand, multiplier_taint, multiplicand_taint,
    input  product, done, product_taint
  );
  modport slave (
    input  start, multiplier, multiplicand, multiplier_taint, multiplicand_taint,
    output product, done, product_taint
  );
`else
  modport master (
    output start, multiplier, multiplicand,
    input  product, done
  );
  modport slave (
    input  start, multiplier, multiplicand,
    output product, done
  );
`endif
endinterface

// File: rtl/multiplier_taint_track_bitwise_taint_adder.sv
// Conservative taint of a sum: output bit i is the OR of both addend taints over bits 0..i.
// Purely combinational, no handshake.
module mult_taint_adder
  import mult_pkg::*;
#(
  parameter int W = 14
) (
  input  logic [W-1:0] a_t,
  input  logic [W-1:0] b_t,
  output logic [W-1:0] sum_t
);

  logic [TAINT_MAX_W-1:0] ab_t;

  assign ab_t = TAINT_MAX_W'(a_t | b_t);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign sum_t[i] = prefix_or_bit(ab_t, i);
  end

endmodule

// File: rtl/multiplier_taint_track_bitwise.sv
// Constant-time shift-and-add multiplier: done pulses NUM_BITS cycles after the start edge;
// no backpressure, start is ignored while running. Taint shadow enabled by MULT_TAINT_TRACK_EN.
module multiplier_taint_track_bitwise
  import mult_pkg::*;
#(
  parameter int NUM_BITS = 7
) (
  input  logic                             clk,
  input  logic                             rst,
  multiplier_taint_track_bitwise_if.slave  bus
);

  localparam int PW = 2 * NUM_BITS;
  localparam int CW = cnt_width(NUM_BITS);
  localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);

  state_t              state, state_nxt;
  logic [PW-1:0]       mcand_r;
  logic [NUM_BITS-1:0] mplier_r;
  logic [PW-1:0]       acc;
  logic [PW-1:0]       acc_nxt;
  logic [PW-1:0]       pp;
  logic [CW-1:0]       cnt;
  logic [PW-1:0]       product_r;
  logic                done_r;

  // Masked partial product keeps every iteration on the same path.
  assign pp      = mcand_r & {PW{mplier_r[0]}};
  assign acc_nxt = acc + pp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_r   <= '0;
      mplier_r  <= '0;
      acc       <= '0;
      cnt       <= '0;
      product_r <= '0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          mcand_r  <= PW'(bus.multiplicand);
          mplier_r <= bus.multiplier;
          acc      <= '0;
          cnt      <= '0;
        end
      end else begin
        acc      <= acc_nxt;
        mcand_r  <= mcand_r << 1;
        mplier_r <= mplier_r >> 1;
        cnt      <= cnt + CW'(1);
        if (cnt == LAST) begin
          product_r <= acc_nxt;
          done_r    <= 1'b1;
        end
      end
    end
  end

  assign bus.product = product_r;
  assign bus.done    = done_r;

`ifdef MULT_TAINT_TRACK_EN
  logic [PW-1:0]       mcand_t;
  logic [PW-1:0]       win;
  logic [NUM_BITS-1:0] mplier_t;
  logic [PW-1:0]       acc_t;
  logic [PW-1:0]       acc_t_nxt;
  logic [PW-1:0]       pp_t;
  logic [PW-1:0]       product_t;

  // win tracks where the shifted multiplicand sits; zeros shifted in are
  // constants, so a tainted multiplier bit only taints that window.
  assign pp_t = mcand_t | ({PW{mplier_t[0]}} & win);

  mult_taint_adder #(.W(PW)) u_taint_add (
    .a_t   (acc_t),
    .b_t   (pp_t),
    .sum_t (acc_t_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_t   <= '0;
      win       <= '0;
      mplier_t  <= '0;
      acc_t     <= '0;
      product_t <= '0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        mcand_t  <= PW'(bus.multiplicand_taint);
        win      <= PW'({NUM_BITS{1'b1}});
        mplier_t <= bus.multiplier_taint;
        acc_t    <= '0;
      end
    end else begin
      acc_t    <= acc_t_nxt;
      mcand_t  <= mcand_t << 1;
      win      <= win << 1;
      mplier_t <= mplier_t >> 1;
      if (cnt == LAST) product_t <= acc_t_nxt;
    end
  end

  assign bus.product_taint = product_t;
`else
  // Plain build: no shadow datapath, the value path above is the whole design.
`endif

endmodule

// File: tb/tb_multiplier_taint_track_bitwise.sv
module tb_multiplier_taint_track_bitwise;
  localparam int N  = 7;
  localparam int PW = 2 * N;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  multiplier_taint_track_bitwise_if #(.NUM_BITS(N)) bus ();

  multiplier_taint_track_bitwise #(.NUM_BITS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Taint rule evaluated as one prefix-OR over the union of all partial-product taints.
  function automatic logic [PW-1:0] taint_model(input logic [N-1:0] mt, input logic [N-1:0] ct);
    logic [PW-1:0] u;
    logic [PW-1:0] r;
    logic          run;
    u = '0;
    for (int i = 0; i < N; i++)
      for (int k = i; k < i + N; k++)
        u[k] = u[k] | ct[k-i] | mt[i];
    run = 1'b0;
    for (int k = 0; k < PW; k++) begin
      run  = run | u[k];
      r[k] = run;
    end
    return r;
  endfunction

  // Reference model: result appears exactly N edges after the accepted start.
  int            cyc = 0;
  int            due = 0;
  bit            busy = 0;
  logic [N-1:0]  m_a = '0, m_b = '0, m_at = '0, m_bt = '0;
  logic [PW-1:0] exp_product = '0;
  logic [PW-1:0] exp_pt = '0;
  logic          exp_done = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy        = 0;
      exp_product = '0;
      exp_pt      = '0;
      exp_done    = 1'b0;
      if (clk) cyc++;
    end else begin
      cyc++;
      exp_done = 1'b0;
      if (!busy) begin
        if (bus.start) begin
          busy = 1;
          due  = cyc + N;
          m_a  = bus.multiplier;
          m_b  = bus.multiplicand;
`ifdef MULT_TAINT_TRACK_EN
          m_at = bus.multiplier_taint;
          m_bt = bus.multiplicand_taint;
`endif
        end
      end else if (cyc == due) begin
        busy        = 0;
        exp_product = PW'(m_a) * PW'(m_b);
        exp_pt      = taint_model(m_at, m_bt);
        exp_done    = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("mon_done", bus.done, exp_done);
      check("mon_product", bus.product, exp_product);
`ifdef MULT_TAINT_TRACK_EN
      check("mon_ptaint", bus.product_taint, exp_pt);
`endif
    end
  end

  task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] at, input logic [N-1:0] bt);
    bus.multiplier   = a;
    bus.multiplicand = b;
`ifdef MULT_TAINT_TRACK_EN
    bus.multiplier_taint   = at;
    bus.multiplicand_taint = bt;
`else
    if (at != bt) begin end
`endif
  endtask

  // Pulse start for one edge, then count edges until done is seen (bounded).
  task automatic wait_done(output int k, output bit found);
    k = 0;
    found = 0;
    repeat (20) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (bus.done) begin
        found = 1;
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] at, input logic [N-1:0] bt,
                        input logic [PW-1:0] exp_p, input logic [PW-1:0] exp_t);
    int k;
    bit found;
    @(posedge clk);
    #2;
    drive(a, b, at, bt);
    bus.start = 1'b1;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    wait_done(k, found);
    check({name, "_found"}, 64'(found), 64'd1);
    check({name, "_latency"}, 64'(k), 64'(N));
    check({name, "_product"}, 64'(bus.product), 64'(exp_p));
`ifdef MULT_TAINT_TRACK_EN
    check({name, "_taint"}, 64'(bus.product_taint), 64'(exp_t));
`else
    if (exp_t != exp_t) begin end
`endif
  endtask

  initial begin
    int k;
    bit found;
    logic [N-1:0] a, b, at, bt;

    bus.start = 1'b0;
    drive('0, '0, '0, '0);
    repeat (2) @(negedge clk);
    check("reset_product", bus.product, '0);
    check("reset_done", bus.done, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;

    run_op("m15x15", 7'd15, 7'd15, 7'd0, 7'd0, 14'd225, 14'h0000);
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("hold_225", bus.product, 14'd225);

    run_op("m0x12", 7'd0, 7'd12, 7'd0, 7'd0, 14'd0, 14'h0000);
    run_op("m1x2", 7'd1, 7'd2, 7'd0, 7'd0, 14'd2, 14'h0000);
    run_op("m0x0", 7'd0, 7'd0, 7'd0, 7'd0, 14'd0, 14'h0000);
    run_op("m92x75", 7'd92, 7'd75, 7'd0, 7'd0, 14'd6900, 14'h0000);
    run_op("m42x78", 7'd42, 7'd78, 7'd0, 7'd0, 14'd3276, 14'h0000);
    run_op("t_cand1", 7'd5, 7'd9, 7'd0, 7'h01, 14'd45, 14'h3FFF);
    run_op("t_mplr40", 7'd99, 7'd33, 7'h40, 7'd0, 14'd3267, 14'h3FC0);

    // Reset asserted after the third iteration edge aborts the multiply.
    @(posedge clk);
    #2;
    drive(7'd127, 7'd127, '0, '0);
    bus.start = 1'b1;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("abort_product", bus.product, '0);
    check("abort_done", bus.done, 1'b0);
    found = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) found = 1;
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) found = 1;
    end
    check("abort_no_done", 64'(found), 64'd0);
    check("abort_idle_product", bus.product, '0);
    run_op("m127x127", 7'd127, 7'd127, 7'd0, 7'd0, 14'd16129, 14'h0000);

    // Operand changes and a second start during RUN must be ignored.
    @(posedge clk);
    #2;
    drive(7'd3, 7'd5, '0, '0);
    bus.start = 1'b1;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    drive(7'd100, 7'd100, 7'h7F, 7'h7F);
    @(posedge clk);
    #2;
    bus.start = 1'b1;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    k = 2;
    found = 0;
    repeat (20) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (bus.done) begin
        found = 1;
        break;
      end
    end
    check("midrun_found", 64'(found), 64'd1);
    check("midrun_latency", 64'(k), 64'(N));
    check("midrun_product", bus.product, 14'd15);
`ifdef MULT_TAINT_TRACK_EN
    check("midrun_taint", bus.product_taint, 14'h0000);
`endif

    for (int i = 0; i < 40; i++) begin
      a  = N'($urandom_range(0, 127));
      b  = N'($urandom_range(0, 127));
      at = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      bt = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      run_op("rand", a, b, at, bt, PW'(a) * PW'(b), taint_model(at, bt));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
